// File: rtl/wbc_arb2.sv
// wbc_arb2: two-master Wishbone arbiter in front of one slave, granted per cyc.
// Ports: wb_clk_i/wb_rst_n clock and async active-low reset; m0_*/m1_* master
//   buses (adr, dat, cyc, stb, we, sel in; dat, ack out); s_* slave bus;
//   gnt_o one-hot {m1,m0}, 00 when idle.
// Build option CONFIG_ARB_RR_EN: round-robin on an idle tie (otherwise master 0 wins).
module wbc_arb2 #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int SW = DW / 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [SW-1:0] m0_sel_i,
  output logic          m0_ack_o,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [SW-1:0] m1_sel_i,
  output logic          m1_ack_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [SW-1:0] s_sel_o,
  input  logic          s_ack_i,
  output logic [1:0]    gnt_o
);
  typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_t;
  state_t state, nxt;
  logic last, tie_m1;
`ifdef CONFIG_ARB_RR_EN
  assign tie_m1 = ~last;
`else
  // Fixed priority: 'last' is tracked but never steers the tie.
  assign tie_m1 = last & 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (m0_cyc_i && m1_cyc_i) ? (tie_m1 ? GNT1 : GNT0) :
                     m0_cyc_i ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
      GNT0:    nxt = m0_cyc_i ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
      GNT1:    nxt = m1_cyc_i ? GNT1 : m0_cyc_i ? GNT0 : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n)
    if (!wb_rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= nxt;
      if (nxt != IDLE) last <= (nxt == GNT1);
    end
  // The grant is the state encoding itself, so it is registered by construction.
  assign gnt_o    = state;
  assign s_cyc_o  = gnt_o[0] ? m0_cyc_i : gnt_o[1] ? m1_cyc_i : 1'b0;
  assign s_stb_o  = gnt_o[0] ? m0_stb_i : gnt_o[1] ? m1_stb_i : 1'b0;
  assign s_we_o   = gnt_o[0] ? m0_we_i  : gnt_o[1] ? m1_we_i  : 1'b0;
  assign s_adr_o  = gnt_o[0] ? m0_adr_i : gnt_o[1] ? m1_adr_i : '0;
  assign s_dat_o  = gnt_o[0] ? m0_dat_i : gnt_o[1] ? m1_dat_i : '0;
  assign s_sel_o  = gnt_o[0] ? m0_sel_i : gnt_o[1] ? m1_sel_i : '0;
  // Qualifying with the master's own cyc drops a late ack after cyc falls.
  assign m0_ack_o = s_ack_i & gnt_o[0] & m0_cyc_i;
  assign m1_ack_o = s_ack_i & gnt_o[1] & m1_cyc_i;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
endmodule

// File: tb/tb_wbc_arb2.sv
// tb_wbc_arb2: scoreboard bench for wbc_arb2 with directed vectors.
module tb_wbc_arb2;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] m0_adr = '0, m0_dat = '0, m1_adr = '0, m1_dat = '0, s_dat = 16'hBEEF;
  logic [15:0] m0_rd, m1_rd, s_adr, s_wd;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0, s_ack = 0;
  logic [1:0]  m0_sel = '0, m1_sel = '0, s_sel, gnt;
  logic        m0_ack, m1_ack, s_cyc, s_stb, s_we;
  typedef struct { string nm; logic [72:0] v; } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  wbc_arb2 dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_rd), .m0_cyc_i(m0_cyc),
    .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel), .m0_ack_o(m0_ack),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_rd), .m1_cyc_i(m1_cyc),
    .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel), .m1_ack_o(m1_ack),
    .s_adr_o(s_adr), .s_dat_o(s_wd), .s_dat_i(s_dat), .s_cyc_o(s_cyc),
    .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel), .s_ack_i(s_ack), .gnt_o(gnt)
  );
  always @(negedge clk)
    while (sb.size() > 0) begin
      automatic exp_t e = sb.pop_front();
      automatic logic [72:0] act = {gnt, s_cyc, s_stb, s_we, s_adr, s_wd, s_sel, m0_ack, m1_ack, m0_rd, m1_rd};
      n_chk++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [1:0] g, input logic c, s, w,
                     input logic [15:0] a, d, input logic [1:0] se, input logic a0, a1);
    sb.push_back('{nm, {g, c, s, w, a, d, se, a0, a1, s_dat, s_dat}});
  endtask
  task automatic z(input string nm);
    chk(nm, 2'b00, 0, 0, 0, 16'h0, 16'h0, 2'b00, 0, 0);
  endtask
  task automatic c0(input string nm, input logic c, s, w, a0);
    chk(nm, 2'b01, c, s, w, 16'h0100, 16'h1234, 2'b11, a0, 0);
  endtask
  task automatic c1(input string nm, input logic c, s, w, a1);
    chk(nm, 2'b10, c, s, w, 16'h0200, 16'h5678, 2'b01, 0, a1);
  endtask
  initial begin
    m1_adr = 16'h0200; m1_dat = 16'h5678; m1_sel = 2'b01;
    tick(); z("rst_hold");
    tick(); rst_n = 1; z("idle");
    tick(); m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 16'h0100; m0_dat = 16'h1234; m0_sel = 2'b11;
    z("t2_latency");
    tick(); c0("t2_gnt", 1, 1, 1, 0);
    tick(); s_ack = 1; c0("t2_ack", 1, 1, 1, 1);
    tick(); s_ack = 0; m0_stb = 0; c0("t2_hold", 1, 0, 1, 0);
    tick(); m0_cyc = 0; m0_we = 0; s_ack = 1; c0("t2_late_ack", 0, 0, 0, 0);
    tick(); s_ack = 0; z("t2_idle");
    tick(); rst_n = 0; z("t1_rst");
    tick(); rst_n = 1; z("t1_idle");
    tick(); m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; z("t3_latency");
    tick(); c0("t3_tie", 1, 1, 0, 0);
    tick(); m0_cyc = 0; m0_stb = 0; c0("t3_drop0", 0, 0, 0, 0);
    tick(); c1("t3_handoff", 1, 1, 0, 0);
    tick(); m1_cyc = 0; m1_stb = 0; c1("t3_drop1", 0, 0, 0, 0);
    tick(); z("t3_idle");
    tick(); m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; z("t4_latency");
    tick(); c0("t4_tie_last1", 1, 1, 0, 0);
    tick(); m0_cyc = 0; m0_stb = 0; c0("t5_drop0", 0, 0, 0, 0);
    tick(); c1("t5_gnt1", 1, 1, 0, 0);
    tick(); m0_cyc = 1; m0_stb = 1; s_ack = 1; c1("t5_ack1", 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); m1_stb = 0; c1("t5_gap", 1, 0, 0, 1);
    end
    tick(); m1_stb = 1; c1("t5_read2", 1, 1, 0, 1);
    tick(); m1_cyc = 0; m1_stb = 0; s_ack = 0; c1("t5_release", 0, 0, 0, 0);
    tick(); c0("t5_handoff", 1, 1, 0, 0);
    tick(); m0_cyc = 0; m0_stb = 0; c0("cfg_drop0", 0, 0, 0, 0);
    tick(); m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; z("cfg_latency");
`ifdef CONFIG_ARB_RR_EN
    tick(); c1("cfg_tie_last0", 1, 1, 0, 0);
    tick(); m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; c1("cfg_drop", 0, 0, 0, 0);
`else
    tick(); c0("cfg_tie_last0", 1, 1, 0, 0);
    tick(); m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; c0("cfg_drop", 0, 0, 0, 0);
`endif
    tick(); m1_cyc = 1; m1_stb = 1; m1_we = 1; z("t6_latency");
    tick(); s_ack = 1; c1("t6_gnt1", 1, 1, 1, 1);
    tick(); rst_n = 0; z("t6_async_rst");
    tick(); rst_n = 1; m0_cyc = 1; m0_stb = 1; z("t6_idle");
    tick(); c0("t6_tie", 1, 1, 0, 1);
    tick(); m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0; s_ack = 0; c0("t6_drop", 0, 0, 0, 0);
    tick(); z("end_idle");
    @(negedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, 0 expected", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
